// File: rtl/spi_seq_pkg.sv
// Shared types and default sizing for the SPI block sequencer.
// The state enum is exported on the top-level debug port.
package spi_seq_pkg;

    localparam int SEQ_WORDS   = 8;
    localparam int SEQ_WORD_W  = 16;
    localparam int SEQ_TIMEOUT = 64;
    localparam int SEQ_IDX_W   = $clog2(SEQ_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_RESULT    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/spi_done_edge.sv
// Registered rising-edge detector for the SPI master's done flag.
// rise is a one-cycle pulse in the first cycle the level is seen high.
module spi_done_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/spi_block_sequencer.sv
// Sends one AES block to the 16-bit SPI master as WORDS word transactions,
// word 0 first, and rebuilds the returned words into a result block.
module spi_block_sequencer
    import spi_seq_pkg::*;
#(
    parameter int WORDS   = SEQ_WORDS,
    parameter int WORD_W  = SEQ_WORD_W,
    parameter int TIMEOUT = SEQ_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    input  logic [WORDS*WORD_W-1:0] blk_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WORDS*WORD_W-1:0] res_data,
    output logic [WORD_W-1:0]       spi_data_in,
    output logic                    spi_data_valid,
    input  logic                    spi_done,
    input  logic [WORD_W-1:0]       spi_data_out,
    output logic                    busy,
    output logic                    timeout_err,
    output seq_state_e              dbg_state
);

    localparam int BLK_W = WORDS * WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // Handshakes (blk_* and res_*): a transfer happens on a rising edge where
    // valid and ready are both high; the source holds valid and data stable
    // until then, and ready here depends on state only, never on valid.

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [BLK_W-1:0]   shadow_q;
    logic [BLK_W-1:0]   res_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [WORD_W-1:0]  last_word_q;
    logic               timeout_err_q;

    logic               done_rise;
    logic               accept;
    logic               abort;
    logic               capture;
    logic               idx_last;
    logic               tmo_last;
    logic [WORD_W-1:0]  issue_word;

    spi_done_edge u_done_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (spi_done),
        .rise    (done_rise)
    );

    assign idx_last   = (idx_q == IDX_W'(WORDS - 1));
    assign tmo_last   = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign issue_word = shadow_q[WORD_W*int'(idx_q) +: WORD_W];
    assign capture    = (state_q == ST_CAPTURE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done edge in the last allowed cycle still wins over the abort.
                if (done_rise) begin
                    state_d = ST_CAPTURE;
                end else if (tmo_last) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_d = idx_last ? ST_RESULT : ST_ISSUE;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            res_q         <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            last_word_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                shadow_q      <= blk_data;
                idx_q         <= '0;
                timeout_err_q <= 1'b0;
            end

            if (state_q == ST_ISSUE) begin
                tmo_q       <= '0;
                last_word_q <= issue_word;
            end else if (state_q == ST_WAIT_DONE && !done_rise && !tmo_last) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            // CAPTURE sits one cycle after the edge so DATA_OUT has settled.
            if (capture) begin
                res_q[WORD_W*int'(idx_q) +: WORD_W] <= spi_data_out;
                if (!idx_last) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end

            if (abort) begin
                timeout_err_q <= 1'b1;
                res_q         <= '0;
                idx_q         <= '0;
            end
        end
    end

    assign blk_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign res_valid      = (state_q == ST_RESULT);
    assign res_data       = res_q;
    assign spi_data_valid = (state_q == ST_ISSUE);
    assign spi_data_in    = (state_q == ST_ISSUE) ? issue_word : last_word_q;
    assign timeout_err    = timeout_err_q;
    assign dbg_state      = state_q;

endmodule
